// File: rtl/sample_rate_gen.sv
// -----------------------------------------------------------------------------
// sample_rate_gen
//
// Programmable sample-rate generator. Takes the period (in clk cycles)
// requested by speed control and produces a one-cycle sample strobe at every
// period boundary. It also drives a level request towards the flash/audio
// reader and flags underruns when the reader misses a whole period.
//
// The requested divisor is clamped to MIN_DIV and shadowed. It is only adopted
// on the IDLE->RUN transition and on the tick that closes a period. Speed
// changes therefore never shorten or stretch the period that is in flight.
//
// Parameters
//   WIDTH    divisor / period counter width
//   MIN_DIV  smallest divisor honoured; smaller requests (including 0) clamp up
//   UCNT_W   width of the saturating underrun counter
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset (deassertion synchronised
//                   outside this block)
//   enable          run/stop; low returns the generator to IDLE
//   pause           freezes the period counter; the handshake keeps running
//   clk_count_to    requested period in clk cycles, from speed control
//   sample_ack      flash reader has taken the current sample
//   clear_underrun  clears underrun and underrun_count on the next edge
//   sample_tick     one-cycle strobe at each period boundary (registered)
//   sample_req      level request, held until acknowledged (registered)
//   underrun        sticky: a period closed with a request still pending
//   underrun_count  number of underruns, saturating at all-ones
//   active_div      divisor of the period in flight, after clamping
// -----------------------------------------------------------------------------
module sample_rate_gen #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MIN_DIV = 16,
  parameter int unsigned UCNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              pause,
  input  logic [WIDTH-1:0]  clk_count_to,
  input  logic              sample_ack,
  input  logic              clear_underrun,
  output logic              sample_tick,
  output logic              sample_req,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_count,
  output logic [WIDTH-1:0]  active_div
);

  // Divisor in force after reset, before speed control has been sampled.
  localparam logic [WIDTH-1:0]  RESET_DIV = WIDTH'(3472);
  localparam logic [WIDTH-1:0]  MIN_DIV_W = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0]  ONE_W     = WIDTH'(1);
  localparam logic [UCNT_W-1:0] UCNT_ONE  = UCNT_W'(1);
  localparam logic [UCNT_W-1:0] UCNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count;         // cycles elapsed in the current period
  logic [WIDTH-1:0] div_clamped;   // clamp(clk_count_to)
  logic             period_end;    // this edge registers a period boundary
  logic             underrun_evt;  // boundary reached with the request unserved

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------

  // Unsigned compare. The result is never below MIN_DIV, so active_div - 1
  // cannot wrap in the period_end compare.
  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    div_clamped = clk_count_to;
    if (clk_count_to < MIN_DIV_W) begin
      div_clamped = MIN_DIV_W;
    end
  end

  // A boundary only exists while actually counting: running, enabled and not
  // paused. A pause parked on the last count simply delays the boundary.
  assign period_end   = (state == RUN) && enable && !pause &&
                        (count == (active_div - ONE_W));

  // The reader missed a period: a new boundary arrives while the previous
  // request is still up and is not being acknowledged on this very edge.
  assign underrun_evt = period_end && sample_req && !sample_ack;

  // ---------------------------------------------------------------------------
  // Control FSM, period counter, tick, request and divisor shadow
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments only, so every
  // register in this block sees pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      sample_tick <= 1'b0;
      sample_req  <= 1'b0;
      active_div  <= RESET_DIV;
    end else begin
      case (state)
        IDLE: begin
          count       <= '0;
          sample_tick <= 1'b0;
          sample_req  <= 1'b0;
          if (enable) begin
            // Latch the first period's divisor here, so the first tick lands
            // exactly active_div cycles after this edge.
            state      <= RUN;
            active_div <= div_clamped;
          end
        end

        RUN: begin
          if (!enable) begin
            // Stopping abandons the period and the request. active_div and
            // the underrun state are deliberately kept.
            state       <= IDLE;
            count       <= '0;
            sample_tick <= 1'b0;
            sample_req  <= 1'b0;
          end else begin
            // Period counter. When paused, count holds so that a pause of P
            // cycles stretches the current period by exactly P cycles.
            if (pause) begin
              sample_tick <= 1'b0;
            end else if (period_end) begin
              count       <= '0;
              sample_tick <= 1'b1;
              // The only point in RUN where a new divisor is adopted. The
              // period just closed always ran at its own latched length.
              active_div  <= div_clamped;
            end else begin
              count       <= count + ONE_W;
              sample_tick <= 1'b0;
            end

            // Request handshake. A boundary always (re)raises the request,
            // even if it coincides with an ack: that ack serves the old
            // sample and the new request stands. An ack seen while req is
            // low falls through both branches and is ignored.
            if (period_end) begin
              sample_req <= 1'b1;
            end else if (sample_req && sample_ack) begin
              sample_req <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Underrun flag and saturating counter
  // ---------------------------------------------------------------------------
  // An event on the same edge as clear_underrun wins: the flag stays set and
  // the counter restarts at one, so the coincident underrun is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (underrun_evt) begin
      underrun <= 1'b1;
      if (clear_underrun) begin
        underrun_count <= UCNT_ONE;
      end else if (underrun_count != UCNT_MAX) begin
        underrun_count <= underrun_count + UCNT_ONE;
      end
    end else if (clear_underrun) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end
  end

endmodule
